// File: rtl/ram_arbiter.sv
// Time-slotted SPRAM arbiter: the CPU owns phases 0-1 of every clk/4 CPU cycle.
// One secondary requester (round-robin) owns phases 2-3.
module ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              cpu_clk,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_sel,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic [1:0]        p_q, p_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              gv_q, gv_d;
    logic              gid_q, gid_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] g_addr_q, g_addr_d;
    logic              g_we_q, g_we_d;
    logic [DATA_W-1:0] g_wdata_q, g_wdata_d;
    logic              win1;

    // Both requesting: the one not granted last time wins.
    assign win1 = req1 & ~(req0 & last_q);

    always_comb begin
        p_d         = p_q + 2'd1;
        cpu_rdata_d = cpu_rdata_q;
        rdata_d     = rdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        gv_d        = gv_q;
        gid_d       = gid_q;
        last_d      = last_q;
        g_addr_d    = g_addr_q;
        g_we_d      = g_we_q;
        g_wdata_d   = g_wdata_q;
        case (p_q)
            2'd1: begin
                if (cpu_sel && !cpu_we) cpu_rdata_d = ram_rdata;
                gv_d = req0 | req1;
                if (req0 || req1) begin
                    gid_d     = win1;
                    last_d    = win1;
                    g_addr_d  = win1 ? addr1 : addr0;
                    g_we_d    = win1 ? we1 : we0;
                    g_wdata_d = win1 ? wdata1 : wdata0;
                end
            end
            2'd3: begin
                if (gv_q) begin
                    if (!g_we_q) rdata_d = ram_rdata;
                    ack0_d = ~gid_q;
                    ack1_d = gid_q;
                    gv_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q         <= 2'd0;
            cpu_rdata_q <= '0;
            rdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            gv_q        <= 1'b0;
            gid_q       <= 1'b0;
            last_q      <= 1'b1;
            g_addr_q    <= '0;
            g_we_q      <= 1'b0;
            g_wdata_q   <= '0;
        end else begin
            p_q         <= p_d;
            cpu_rdata_q <= cpu_rdata_d;
            rdata_q     <= rdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            gv_q        <= gv_d;
            gid_q       <= gid_d;
            last_q      <= last_d;
            g_addr_q    <= g_addr_d;
            g_we_q      <= g_we_d;
            g_wdata_q   <= g_wdata_d;
        end
    end

    logic use_grant;
    assign use_grant = p_q[1] & gv_q;

    always_comb begin
        ram_we = 1'b0;
        case (p_q)
            2'd0:    ram_we = cpu_sel & cpu_we;
            2'd2:    ram_we = gv_q & g_we_q;
            default: ram_we = 1'b0;
        endcase
        // Write strobe must die with reset even while the CPU still drives it.
        if (reset) ram_we = 1'b0;
    end

    assign ram_addr  = use_grant ? g_addr_q : cpu_addr;
    assign ram_wdata = use_grant ? g_wdata_q : cpu_wdata;
    assign cpu_clk   = p_q[1];
    assign cpu_rdata = cpu_rdata_q;
    assign rdata     = rdata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, SPRAM address width (32 KiB bank).
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 clk  input  1  63 MHz system clock; sole clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_clk  output  1  CPU clock, clk/4; high during phases 2-3.
REQ-006 cpu_addr  input  ADDR_W  CPU RAM address.
REQ-007 cpu_sel  input  1  CPU RAM chip select (decoded outside).
REQ-008 cpu_we  input  1  CPU write strobe.
REQ-009 cpu_wdata  input  DATA_W  CPU write data.
REQ-010 cpu_rdata  output  DATA_W  latched CPU read data.
REQ-011 req0, req1  input  1 each  secondary requester (VDP fetch, blitter) access request.
REQ-012 addr0, addr1  input  ADDR_W each  requester addresses.
REQ-013 we0, we1  input  1 each  requester write flags.
REQ-014 wdata0, wdata1  input  DATA_W each  requester write data.
REQ-015 ack0, ack1  output  1 each  one-clk completion pulse.
REQ-016 rdata  output  DATA_W  shared requester read data; valid while ack is high.
REQ-017 ram_addr  output  ADDR_W  SPRAM address.
REQ-018 ram_we  output  1  SPRAM write enable.
REQ-019 ram_wdata  output  DATA_W  SPRAM write data.
REQ-020 ram_rdata  input  DATA_W  SPRAM registered read data; one-clk latency.

Function
REQ-021 2-bit phase counter p increments every clk, wrapping 3->0; cpu_clk SHALL equal p[1].
REQ-022 Phase 0: ram_addr = cpu_addr, ram_wdata = cpu_wdata, ram_we = cpu_sel & cpu_we.
REQ-023 Phase 1: ram_addr = cpu_addr, ram_we = 0; on the edge ending phase 1, cpu_rdata <= ram_rdata if cpu_sel & ~cpu_we, else hold.
REQ-024 On the edge ending phase 1, req0/req1 are sampled; winner's addr/we/wdata are captured into registers, grant_valid and grant_id are set.
REQ-025 Arbitration is round-robin: a single requester always wins; if both request, the one not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-026 Phases 2-3 with grant_valid: ram_addr and ram_wdata come from the captured registers; ram_we = captured we in phase 2 only.
REQ-027 Phases 2-3 without grant_valid: ram_we = 0; ram_addr holds cpu_addr.
REQ-028 On the edge ending phase 3 with grant_valid: rdata <= ram_rdata for reads (held for writes); ack[grant_id] = 1 for exactly the next clk (phase 0); grant_valid clears.
REQ-029 Latency: ack asserts 2 clks after the sampling edge, giving at most one secondary transfer per CPU cycle.
REQ-030 Requesters hold req, addr, we and wdata until ack, and drop req in the ack cycle. A req still high at the next phase-1 edge is a new request.
REQ-031 Requester input changes outside the sampling edge have no effect on an in-flight grant.
REQ-032 ack0 and ack1 are never both high; ram_we is high at most 2 clks per 4 (phases 0 and 2).
REQ-033 A CPU write and a requester read to the same address in one CPU cycle: the requester read returns the CPU-written value, because phase 0 precedes phase 2.

Reset
REQ-034 Reset asynchronously forces p=0, cpu_clk=0, cpu_rdata=0, rdata=0, ack0=ack1=0, grant_valid=0, last_grant=1, ram_we=0.
REQ-035 Reset mid-grant abandons the transfer: no ack, and no write if asserted before phase 2.
REQ-036 After release, p counts from 0; the first sampling edge is at the end of the second clk.

Verification
REQ-037 Scenario: reset released, CPU writes 0x5A to 0x0123 -> ram_we high in phase 0 only with ram_addr 0x0123; a following CPU read gives cpu_rdata 0x5A before cpu_clk rises.
REQ-038 Scenario: req0 alone reads 0x7FFF (preloaded 0xC3) -> ack0 pulses one clk in phase 0, 2 clks after sampling, with rdata 0xC3; ack1 stays 0.
REQ-039 Scenario: req0 and req1 held continuously -> grants alternate 0,1,0,1 over 4 CPU cycles; the first tie goes to req0.
REQ-040 Scenario: req1 write 0x99 to 0x0010 while CPU reads 0x0020 -> ram_we in phase 2 at 0x0010; CPU data unaffected; ack1 pulses once.
REQ-041 Scenario: reset asserted in phase 2 of a req0 write -> no ack0; ram_we drops immediately; outputs at reset values.
REQ-042 Scenario: CPU writes 0x11 and req0 reads the same address 0x0400 in one CPU cycle -> rdata 0x11.
